// File: rtl/spu_pkg.sv
// Shared SPU definitions: datapath widths, local-store unit id and addressing helpers.
package spu_pkg;

    localparam int QW_WIDTH      = 128;
    localparam int UNIT_ID_WIDTH = 3;
    localparam logic [UNIT_ID_WIDTH-1:0] UNIT_LS = 3'd7;
    localparam int LS_ADDR_BITS  = 18;

    // Keeps the 18-bit local-store range and forces quadword alignment.
    localparam logic [31:0] LS_QW_MASK = 32'((64'd1 << LS_ADDR_BITS) - 64'd16);

    typedef logic [QW_WIDTH-1:0] qword_t;

    typedef enum logic [1:0] {
        LS_OP_NONE  = 2'd0,
        LS_OP_LOAD  = 2'd1,
        LS_OP_STORE = 2'd2
    } ls_op_t;

    function automatic logic [31:0] ls_byte_addr(input logic [31:0] ea_word);
        return ea_word & LS_QW_MASK;
    endfunction

    function automatic ls_op_t ls_decode(input logic [UNIT_ID_WIDTH-1:0] unit_id,
                                         input logic reg_write_en);
        if (unit_id != UNIT_LS)
            return LS_OP_NONE;
        return reg_write_en ? LS_OP_LOAD : LS_OP_STORE;
    endfunction

endpackage

// File: rtl/data_memory_if.sv
// Odd-pipe stage-7 local-store access bundle: request fields in, loaded quadword out.
interface data_memory_if;
    import spu_pkg::*;

    logic [QW_WIDTH-1:0]      address;
    qword_t                   write_data;
    logic [UNIT_ID_WIDTH-1:0] unit_id;
    logic                     reg_write_en;
    qword_t                   read_data;

    modport master (
        output address,
        output write_data,
        output unit_id,
        output reg_write_en,
        input  read_data
    );

    modport slave (
        input  address,
        input  write_data,
        input  unit_id,
        input  reg_write_en,
        output read_data
    );

endinterface

// File: rtl/data_memory_array.sv
// Single-port quadword RAM with asynchronous read; write on rising edge.
// DMEM_RESET_CLEAR_EN adds a clear input that zeroes every entry at the edge.
module data_memory_array
    import spu_pkg::*;
#(
    parameter int DEPTH = 2048,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
`ifdef DMEM_RESET_CLEAR_EN
    input  logic             clear,
`endif
    input  logic             we,
    input  logic [IDX_W-1:0] index,
    input  qword_t           wdata,
    output qword_t           rdata
);

    qword_t mem [DEPTH];

`ifdef DMEM_RESET_CLEAR_EN
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (we) begin
            mem[index] <= wdata;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (we)
            mem[index] <= wdata;
    end
`endif

    // Read is combinational so a load sees pre-edge contents in its own cycle.
    assign rdata = mem[index];

endmodule

// File: rtl/data_memory.sv
// SPU local-store data memory: address masking, load/store decode, reset gating.
// Optional DMEM_RESET_CLEAR_EN: a reset cycle also clears the whole array.
module data_memory
    import spu_pkg::*;
#(
    parameter int DEPTH_QW = 2048
) (
    input  logic         clk,
    input  logic         reset,
    data_memory_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH_QW);

    logic [31:0]      byte_addr;
    logic [IDX_W-1:0] index;
    ls_op_t           op;
    logic             do_load;
    logic             do_store;
    qword_t           array_rdata;
    logic             unused_bits;

    // Byte address lives in the preferred slot; misaligned low bits are dropped.
    assign byte_addr = ls_byte_addr(bus.address[127:96]);
    assign index     = byte_addr[4 +: IDX_W];

    assign op       = ls_decode(bus.unit_id, bus.reg_write_en);
    assign do_load  = (op == LS_OP_LOAD)  && !reset;
    assign do_store = (op == LS_OP_STORE) && !reset;

    data_memory_array #(
        .DEPTH (DEPTH_QW)
    ) u_array (
        .clk   (clk),
`ifdef DMEM_RESET_CLEAR_EN
        .clear (reset),
`endif
        .we    (do_store),
        .index (index),
        .wdata (bus.write_data),
        .rdata (array_rdata)
    );

    assign bus.read_data = do_load ? array_rdata : '0;

    // Non-preferred slots and out-of-range address bits are intentionally ignored.
    assign unused_bits = ^{bus.address[95:0], byte_addr};

endmodule

// File: tb/tb_data_memory.sv
// Randomized plus directed bench for data_memory against an array reference model.
module tb_data_memory;
    import spu_pkg::*;

    localparam int DEPTH = 2048;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_memory_if bus();

    data_memory #(.DEPTH_QW(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    qword_t model_mem [DEPTH];
    bit     model_valid [DEPTH];
    qword_t last_rd;
    int     n_checks = 0;
    int     n_fail   = 0;
    int     n_txn    = 0;

    task automatic check_eq(input string tag, input qword_t obs, input qword_t exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Local store is 256 KiB of bytes; the DUT holds DEPTH quadwords of it, mirrored.
    function automatic int model_idx(input logic [31:0] ea);
        return int'((ea % 32'h40000) / 16) % DEPTH;
    endfunction

    task automatic do_cycle(input string tag, input bit rst, input logic [2:0] uid,
                            input bit rwe, input logic [31:0] ea, input qword_t wd);
        int idx;
        bit is_load;
        reset            = rst;
        bus.unit_id      = uid;
        bus.reg_write_en = rwe;
        bus.address      = {ea, $urandom(), $urandom(), $urandom()};
        bus.write_data   = wd;
        idx     = model_idx(ea);
        is_load = !rst && (uid == 3'd7) && rwe;
        @(negedge clk);
        last_rd = bus.read_data;
        if (is_load) begin
            if (model_valid[idx])
                check_eq(tag, last_rd, model_mem[idx]);
        end else begin
            check_eq(tag, last_rd, '0);
        end
        @(posedge clk);
        if (rst) begin
`ifdef DMEM_RESET_CLEAR_EN
            for (int i = 0; i < DEPTH; i++) begin
                model_mem[i]   = '0;
                model_valid[i] = 1'b1;
            end
`endif
        end else if (uid == 3'd7 && !rwe) begin
            model_mem[idx]   = wd;
            model_valid[idx] = 1'b1;
        end
        #1;
        n_txn++;
        $display("txn %0d %s rst=%0b uid=%0d rwe=%0b ea=%h wd=%h rd=%h",
                 n_txn, tag, rst, uid, rwe, ea, wd, last_rd);
    endtask

    function automatic qword_t rand_qw();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    qword_t pat_a, pat_b, pat_c, pat_d, pre_reset;

    initial begin
        for (int i = 0; i < DEPTH; i++) model_valid[i] = 1'b0;
        reset = 1'b1;
        bus.unit_id = 3'd0; bus.reg_write_en = 1'b0;
        bus.address = '0; bus.write_data = '0;
        @(posedge clk); #1;

        // Reset holds read_data at zero even for a load request.
        do_cycle("rst_load", 1'b1, 3'd7, 1'b1, 32'h20, '0);
        do_cycle("rst_store", 1'b1, 3'd7, 1'b0, 32'h20, rand_qw());

        pat_a = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        do_cycle("st_20", 1'b0, 3'd7, 1'b0, 32'h20, pat_a);
        do_cycle("ld_20", 1'b0, 3'd7, 1'b1, 32'h20, '0);
        check_eq("ld_20_const", last_rd, pat_a);
        do_cycle("ld_2b", 1'b0, 3'd7, 1'b1, 32'h2B, '0);
        check_eq("ld_2b_const", last_rd, pat_a);

        pat_b = {16{8'hA5}};
        do_cycle("st_8010", 1'b0, 3'd7, 1'b0, 32'h8010, pat_b);
        do_cycle("ld_10", 1'b0, 3'd7, 1'b1, 32'h10, '0);
        check_eq("wrap_const", last_rd, pat_b);

        do_cycle("u3_store", 1'b0, 3'd3, 1'b0, 32'h20, rand_qw());
        do_cycle("ld_after_u3", 1'b0, 3'd7, 1'b1, 32'h20, '0);
        check_eq("u3_no_write", last_rd, pat_a);

        pre_reset = pat_a;
        do_cycle("rst_cancel", 1'b1, 3'd7, 1'b0, 32'h20, rand_qw());
        do_cycle("ld_post_rst", 1'b0, 3'd7, 1'b1, 32'h20, '0);
`ifdef DMEM_RESET_CLEAR_EN
        check_eq("post_rst_const", last_rd, '0);
`else
        check_eq("post_rst_const", last_rd, pre_reset);
`endif

        pat_c = rand_qw();
        pat_d = rand_qw();
        do_cycle("st_40", 1'b0, 3'd7, 1'b0, 32'h40, pat_c);
        do_cycle("st_50", 1'b0, 3'd7, 1'b0, 32'h50, pat_d);
        do_cycle("ld_40", 1'b0, 3'd7, 1'b1, 32'h40, '0);
        check_eq("ld_40_const", last_rd, pat_c);
        do_cycle("ld_50", 1'b0, 3'd7, 1'b1, 32'h50, '0);
        check_eq("ld_50_const", last_rd, pat_d);

        // Random mix over a small set of entries so loads hit stored data often.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ea;
            logic [2:0]  uid;
            bit          rwe, rst;
            ea  = ($urandom() & 32'hFFFE_800F)
                | (32'($urandom_range(0, 15)) << 4)
                | (32'($urandom_range(0, 1)) << 15);
            uid = ($urandom_range(0, 9) < 7) ? 3'd7 : 3'($urandom_range(0, 6));
            rwe = bit'($urandom_range(0, 1));
            rst = ($urandom_range(0, 29) == 0);
            do_cycle("rand", rst, uid, rwe, ea, rand_qw());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
